// File: rtl/prio_enc_16to4_seq.sv
// Sequential 16-to-4 priority encoder: captures a request vector and emits one encoded beat per set bit.
// Optional sticky overrun flag `err` is built when PRIO_ENC_OVERRUN_EN is defined.
module prio_enc_16to4_seq #(
  parameter int PRIO_HIGH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e,
  input  logic [15:0] d,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  y,
  output logic        zero,
  output logic        last,
  output logic        out_valid,
  input  logic        out_ready
`ifdef PRIO_ENC_OVERRUN_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_pend;

  state_t      w_state_nxt;
  logic [15:0] w_pend_nxt;
  logic        w_accept;
  logic        w_xfer;
  logic [3:0]  w_sel;
  logic        w_last_cur;

  // Index of the bit served next; an empty vector maps to 0.
  function automatic logic [3:0] f_sel_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) idx = 4'(i);
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (v[i]) idx = 4'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic f_single(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  // An all-zero capture is a single final beat.
  function automatic logic f_last(input logic [15:0] v);
    return (v == 16'd0) || f_single(v);
  endfunction

  assign in_ready = (r_state == IDLE) & e;

  // Next-state and next-pending computation.
  always_comb begin
    w_accept    = in_valid & in_ready;
    w_xfer      = out_valid & out_ready;
    w_sel       = f_sel_idx(r_pend);
    w_last_cur  = f_last(r_pend);
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_pend_nxt  = d;
          w_state_nxt = EMIT;
        end else begin
          w_pend_nxt  = r_pend;
          w_state_nxt = IDLE;
        end
      end
      EMIT: begin
        if (w_xfer) begin
          w_pend_nxt = r_pend & ~(16'd1 << w_sel);
          if (w_last_cur) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = EMIT;
          end
        end else begin
          w_pend_nxt  = r_pend;
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_pend_nxt  = 16'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, pending vector and registered beat outputs (derived from the next pending value).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pend    <= 16'd0;
      out_valid <= 1'b0;
      y         <= 4'd0;
      zero      <= 1'b0;
      last      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_state_nxt == EMIT) begin
        out_valid <= 1'b1;
        y         <= f_sel_idx(w_pend_nxt);
        zero      <= (w_pend_nxt == 16'd0);
        last      <= f_last(w_pend_nxt);
      end else begin
        out_valid <= 1'b0;
        y         <= 4'd0;
        zero      <= 1'b0;
        last      <= 1'b0;
      end
    end
  end

`ifdef PRIO_ENC_OVERRUN_EN
  // Sticky overrun: a request presented while a capture is still being emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_valid && (r_state == EMIT)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`endif

endmodule

// File: tb/tb_prio_enc_16to4_seq.sv
// Self-checking bench for prio_enc_16to4_seq: unit 0 uses PRIO_HIGH=1, unit 1 uses PRIO_HIGH=0.
// Expected beats come from a per-capture list of set-bit indices built in priority order.
module tb_prio_enc_16to4_seq;

  logic        clk;
  logic        rst_a  [2];
  logic        e_a    [2];
  logic [15:0] d_a    [2];
  logic        iv_a   [2];
  logic        rdy_a  [2];
  logic [3:0]  y_a    [2];
  logic        zero_a [2];
  logic        last_a [2];
  logic        ov_a   [2];
  logic        ordy_a [2];
`ifdef PRIO_ENC_OVERRUN_EN
  logic        err_a  [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state per unit
  int m_list [2][16];
  int m_cnt  [2];
  int m_pos  [2];
  bit m_busy [2];
  bit m_zero [2];
  bit m_err  [2];

  prio_enc_16to4_seq #(.PRIO_HIGH(1)) u_hi (
    .clk(clk), .rst(rst_a[0]), .e(e_a[0]), .d(d_a[0]), .in_valid(iv_a[0]),
    .in_ready(rdy_a[0]), .y(y_a[0]), .zero(zero_a[0]), .last(last_a[0]),
    .out_valid(ov_a[0]), .out_ready(ordy_a[0])
`ifdef PRIO_ENC_OVERRUN_EN
    , .err(err_a[0])
`endif
  );

  prio_enc_16to4_seq #(.PRIO_HIGH(0)) u_lo (
    .clk(clk), .rst(rst_a[1]), .e(e_a[1]), .d(d_a[1]), .in_valid(iv_a[1]),
    .in_ready(rdy_a[1]), .y(y_a[1]), .zero(zero_a[1]), .last(last_a[1]),
    .out_valid(ov_a[1]), .out_ready(ordy_a[1])
`ifdef PRIO_ENC_OVERRUN_EN
    , .err(err_a[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle on unit u: drive inputs, observe {out_valid,in_ready,zero,last,y}, advance the model.
  task automatic cyc(input int u, input logic rs, input logic ee, input logic iv,
                     input logic [15:0] dd, input logic ordy,
                     output logic [7:0] act, output logic [7:0] exp);
    @(negedge clk);
    rst_a[u] = rs; e_a[u] = ee; iv_a[u] = iv; d_a[u] = dd; ordy_a[u] = ordy;
    #1;
    act = {ov_a[u], rdy_a[u], zero_a[u], last_a[u], y_a[u]};
    if (m_busy[u])
      exp = {1'b1, 1'b0, m_zero[u], (m_pos[u] == m_cnt[u] - 1) ? 1'b1 : 1'b0,
             4'(m_list[u][m_pos[u]])};
    else
      exp = {1'b0, ee, 1'b0, 1'b0, 4'd0};
    if (rs) begin
      m_busy[u] = 1'b0;
      m_err[u]  = 1'b0;
    end else begin
      if (m_busy[u] && iv) m_err[u] = 1'b1;
      if (!m_busy[u]) begin
        if (iv && ee) begin
          m_cnt[u] = 0;
          for (int k = 0; k < 16; k++) begin
            int b;
            b = (u == 0) ? 15 - k : k;
            if (dd[b]) begin
              m_list[u][m_cnt[u]] = b;
              m_cnt[u]++;
            end
          end
          m_zero[u] = (m_cnt[u] == 0);
          if (m_cnt[u] == 0) begin
            m_list[u][0] = 0;
            m_cnt[u]     = 1;
          end
          m_pos[u]  = 0;
          m_busy[u] = 1'b1;
        end
      end else if (ordy) begin
        m_pos[u]++;
        if (m_pos[u] == m_cnt[u]) m_busy[u] = 1'b0;
      end
    end
  endtask

  // Leave unit u idle with in_valid low so it does nothing while the other unit is exercised.
  task automatic drain(input int u);
    logic [7:0] a, x;
    cyc(u, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    for (int i = 0; i < 20; i++) begin
      if (m_busy[u]) cyc(u, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    end
  endtask

  task automatic test_reset;
    logic [7:0] a, x;
    for (int u = 0; u < 2; u++) begin
      rst_a[u] = 1'b1; e_a[u] = 1'b1; iv_a[u] = 1'b0; d_a[u] = 16'h0000; ordy_a[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      cyc(u, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, a, x);
      n_cmp++;
      if (a !== 8'b0100_0000 || a !== x) begin
        n_bad++;
        $display("FAIL reset_e1 u%0d: got %b expected %b", u, a, 8'b0100_0000);
      end
      cyc(u, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, a, x);
      n_cmp++;
      if (a !== 8'b0000_0000) begin
        n_bad++;
        $display("FAIL reset_e0 u%0d: got %b expected %b", u, a, 8'b0000_0000);
      end
      cyc(u, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, a, x);
    end
  endtask

  task automatic test_zero_capture;
    logic [7:0] a, x;
    cyc(0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, a, x);
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (a !== {1'b1, 1'b0, 1'b1, 1'b1, 4'd0} || a !== x) begin
      n_bad++;
      $display("FAIL zero_beat: got %b expected %b", a, x);
    end
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL zero_back_idle: got %b expected %b", a, x);
    end
    drain(0);
  endtask

  task automatic test_8421;
    logic [7:0] a, x;
    int exp_y [4] = '{15, 10, 5, 0};
    cyc(0, 1'b0, 1'b1, 1'b1, 16'h8421, 1'b1, a, x);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
      n_cmp++;
      if (a !== x || a[3:0] !== 4'(exp_y[i]) || a[4] !== (i == 3)) begin
        n_bad++;
        $display("FAIL beat8421_%0d: got %b expected y=%0d last=%0d", i, a, exp_y[i], (i == 3));
      end
    end
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL after8421: got %b expected %b", a, x);
    end
    drain(0);
  endtask

  task automatic test_hold;
    logic [7:0] a, x;
    cyc(1, 1'b0, 1'b1, 1'b1, 16'h0012, 1'b0, a, x);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, a, x);
      n_cmp++;
      if (a !== x || a[3:0] !== 4'd1 || a[7] !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_%0d: got %b expected %b", i, a, x);
      end
    end
    cyc(1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (a !== x || a[3:0] !== 4'd1 || a[4] !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_rel1: got %b expected %b", a, x);
    end
    cyc(1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (a !== x || a[3:0] !== 4'd4 || a[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_rel4: got %b expected %b", a, x);
    end
    drain(1);
  endtask

  task automatic test_enable;
    logic [7:0] a, x;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, a, x);
      n_cmp++;
      if (a !== x || a[6] !== 1'b0 || a[7] !== 1'b0) begin
        n_bad++;
        $display("FAIL enable_blocked_%0d: got %b expected %b", i, a, x);
      end
    end
    cyc(0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, a, x);
    n_cmp++;
    if (a !== x || a[6] !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_accept: got %b expected %b", a, x);
    end
    cyc(0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (a !== x || a !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL enable_beat: got %b expected %b", a, x);
    end
    drain(0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] a, x;
    cyc(0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, a, x);
    for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    cyc(0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, a, x);
    n_cmp++;
    if (a !== x || a[3:0] !== 4'd10) begin
      n_bad++;
      $display("FAIL rstmid_6th_shown: got %b expected %b", a, x);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
      n_cmp++;
      if (a !== x || a[7] !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_no_beat_%0d: got %b expected %b", i, a, x);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, x;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 60; i++) begin
        logic [15:0] dd;
        dd = 16'((32'd1 << $urandom_range(15, 0)) | (32'd1 << $urandom_range(15, 0)));
        cyc(u, 1'b0, 1'b1, 1'b1, dd, 1'b1, a, x);
        n_cmp++;
        if (a !== x) begin
          n_bad++;
          $display("FAIL b2b u%0d cyc%0d: got %b expected %b", u, i, a, x);
        end
      end
      drain(u);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, x;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 300; i++) begin
        logic [15:0] dd;
        logic rs, ee, iv, ordy;
        case ($urandom_range(3, 0))
          0: dd = 16'h0000;
          1: dd = 16'(32'd1 << $urandom_range(15, 0));
          default: dd = 16'($urandom);
        endcase
        rs   = ($urandom_range(49, 0) == 0);
        ee   = ($urandom_range(3, 0) != 0);
        iv   = ($urandom_range(2, 0) != 0);
        ordy = ($urandom_range(2, 0) != 0);
        cyc(u, rs, ee, iv, dd, ordy, a, x);
        n_cmp++;
        if (a !== x) begin
          n_bad++;
          $display("FAIL rand u%0d cyc%0d: got %b expected %b", u, i, a, x);
        end
      end
      drain(u);
    end
  endtask

`ifdef PRIO_ENC_OVERRUN_EN
  task automatic test_overrun;
    logic [7:0] a, x;
    cyc(0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, a, x);
    cyc(0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, a, x);
    cyc(0, 1'b0, 1'b1, 1'b1, 16'hF000, 1'b1, a, x);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
      n_cmp++;
      if (a !== x || err_a[0] !== 1'b1 || err_a[0] !== m_err[0]) begin
        n_bad++;
        $display("FAIL overrun_%0d: got %b err=%b expected %b err=1", i, a, err_a[0], x);
      end
    end
    cyc(0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a, x);
    n_cmp++;
    if (err_a[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear: got err=%b expected 0", err_a[0]);
    end
  endtask
`endif

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_a[u] = 1'b1; e_a[u] = 1'b0; iv_a[u] = 1'b0; d_a[u] = 16'h0000; ordy_a[u] = 1'b0;
      m_busy[u] = 1'b0; m_err[u] = 1'b0; m_cnt[u] = 0; m_pos[u] = 0; m_zero[u] = 1'b0;
    end
    test_reset();
    test_zero_capture();
    test_8421();
    test_hold();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef PRIO_ENC_OVERRUN_EN
    test_overrun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
